// File: rtl/averager_moving_powers_of_two_if.sv
// Sample/average handshake bundle for averager_moving_powers_of_two.
// master = upstream/downstream datapath side, slave = the averager.
interface averager_moving_powers_of_two_if #(
    parameter int WORD_WIDTH     = 16,
    parameter int EXPONENT_WIDTH = 3
);
    logic [EXPONENT_WIDTH-1:0]      window_exponent;
    logic                           restart_average;
    logic                           input_valid;
    logic                           input_ready;
    logic signed [WORD_WIDTH-1:0]   input_sample;
    logic                           input_overflow;
    logic                           output_valid;
    logic                           output_ready;
    logic signed [WORD_WIDTH-1:0]   output_average;

    modport master (
        output window_exponent, restart_average, input_valid, input_sample, output_ready,
        input  input_ready, input_overflow, output_valid, output_average
    );

    modport slave (
        input  window_exponent, restart_average, input_valid, input_sample, output_ready,
        output input_ready, input_overflow, output_valid, output_average
    );
endinterface

// File: rtl/averager_moving_powers_of_two.sv
// Sliding-window (boxcar) average over a runtime-selectable 2^E window, divide by shift.
// Define AVERAGER_MOVING_ROUNDING_EN for round-half-away-from-zero with saturation.
//
//  state   | meaning
//  FILLING | fewer than 2^E samples in the window, no outputs yet
//  RUNNING | window full, every accepted sample produces an average
module averager_moving_powers_of_two #(
    parameter int WORD_WIDTH     = 16,
    parameter int MAX_EXPONENT   = 4,
    parameter int EXPONENT_WIDTH = 3
) (
    input  logic                          i_clock,
    input  logic                          i_clear,
    averager_moving_powers_of_two_if.slave bus
);
    localparam int DEPTH = 1 << MAX_EXPONENT;
    localparam int ACC_W = WORD_WIDTH + MAX_EXPONENT;
    localparam int EXT_W = ACC_W + 2;
    localparam int DIV_W = ACC_W + 1;
    localparam int PTR_W = (MAX_EXPONENT > 0) ? MAX_EXPONENT : 1;
    localparam int CNT_W = MAX_EXPONENT + 1;

    typedef enum logic {
        FILLING = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic                         r_restart_q;
    logic [EXPONENT_WIDTH-1:0]    r_exp;
    logic signed [ACC_W-1:0]      r_sum;
    logic [CNT_W-1:0]             r_fill_count;
    logic [PTR_W-1:0]             r_wr_ptr;
    logic                         r_out_valid;
    logic signed [WORD_WIDTH-1:0] r_out_avg;
    logic                         r_overflow;
    logic signed [WORD_WIDTH-1:0] r_history [DEPTH];

    logic [EXPONENT_WIDTH-1:0]    w_exp_clamped;
    logic [CNT_W-1:0]             w_window;
    logic                         w_producing;
    logic                         w_restart_pulse;
    logic                         w_input_ready;
    logic                         w_accept;
    logic [PTR_W-1:0]             w_rd_ptr;
    logic signed [WORD_WIDTH-1:0] w_old;
    logic signed [EXT_W-1:0]      w_sum_ext;
    logic                         w_overflow;
    logic signed [ACC_W-1:0]      w_sum_next;
    logic signed [DIV_W-1:0]      w_sum_div;
    logic signed [DIV_W-1:0]      w_bias;
    logic signed [DIV_W-1:0]      w_biased;
    logic signed [WORD_WIDTH-1:0] w_avg;

    always_comb begin
        w_exp_clamped = bus.window_exponent;
        if (bus.window_exponent > EXPONENT_WIDTH'(MAX_EXPONENT))
            w_exp_clamped = EXPONENT_WIDTH'(MAX_EXPONENT);
    end

    assign w_window        = CNT_W'(1) << r_exp;
    assign w_producing     = (r_state == RUNNING) || (r_fill_count == w_window - CNT_W'(1));
    assign w_restart_pulse = bus.restart_average & ~r_restart_q;
    assign w_input_ready   = !w_restart_pulse && (!w_producing || !r_out_valid || bus.output_ready);
    assign w_accept        = bus.input_valid && w_input_ready;

    // Sample leaving the window sits 2^E slots behind the write pointer.
    assign w_rd_ptr  = r_wr_ptr - w_window[PTR_W-1:0];
    assign w_old     = (r_state == RUNNING) ? r_history[w_rd_ptr] : '0;

    assign w_sum_ext = {{(EXT_W-ACC_W){r_sum[ACC_W-1]}}, r_sum}
                     + {{(EXT_W-WORD_WIDTH){bus.input_sample[WORD_WIDTH-1]}}, bus.input_sample}
                     - {{(EXT_W-WORD_WIDTH){w_old[WORD_WIDTH-1]}}, w_old};
    assign w_overflow = !((&w_sum_ext[EXT_W-1:ACC_W-1]) || !(|w_sum_ext[EXT_W-1:ACC_W-1]));
    assign w_sum_next = w_sum_ext[ACC_W-1:0];
    assign w_sum_div  = {w_sum_next[ACC_W-1], w_sum_next};

`ifdef AVERAGER_MOVING_ROUNDING_EN
    localparam logic signed [DIV_W-1:0] SAT_MAX = {{(DIV_W-WORD_WIDTH+1){1'b0}}, {(WORD_WIDTH-1){1'b1}}};
    localparam logic signed [DIV_W-1:0] SAT_MIN = {{(DIV_W-WORD_WIDTH+1){1'b1}}, {(WORD_WIDTH-1){1'b0}}};
    logic signed [DIV_W-1:0] w_half;
    logic signed [DIV_W-1:0] w_quot;

    // Negative side: truncating (sum - half) toward zero equals floor(sum + half - 1).
    always_comb begin
        w_half = '0;
        w_bias = '0;
        if (r_exp != '0) begin
            w_half = DIV_W'(1) << (r_exp - EXPONENT_WIDTH'(1));
            w_bias = w_sum_next[ACC_W-1] ? (w_half - DIV_W'(1)) : w_half;
        end
    end

    assign w_biased = w_sum_div + w_bias;
    assign w_quot   = w_biased >>> r_exp;

    always_comb begin
        w_avg = w_quot[WORD_WIDTH-1:0];
        if (w_quot > SAT_MAX)
            w_avg = SAT_MAX[WORD_WIDTH-1:0];
        else if (w_quot < SAT_MIN)
            w_avg = SAT_MIN[WORD_WIDTH-1:0];
    end
`else
    assign w_bias   = w_sum_next[ACC_W-1] ? ((DIV_W'(1) << r_exp) - DIV_W'(1)) : '0;
    assign w_biased = w_sum_div + w_bias;
    assign w_avg    = WORD_WIDTH'(w_biased >>> r_exp);
`endif

    always_comb begin
        w_state_next = r_state;
        if (w_restart_pulse)
            w_state_next = FILLING;
        else if (w_accept && w_producing)
            w_state_next = RUNNING;
    end

    always_ff @(posedge i_clock) begin
        if (i_clear)
            r_state <= FILLING;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge i_clock) begin
        r_restart_q <= bus.restart_average;
        if (i_clear || w_restart_pulse) begin
            r_exp        <= w_exp_clamped;
            r_sum        <= '0;
            r_fill_count <= '0;
            r_wr_ptr     <= '0;
            r_out_valid  <= 1'b0;
            r_out_avg    <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (r_out_valid && bus.output_ready)
                r_out_valid <= 1'b0;
            if (w_accept) begin
                r_sum    <= w_sum_next;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (r_state == FILLING)
                    r_fill_count <= r_fill_count + CNT_W'(1);
                if (w_overflow)
                    r_overflow <= 1'b1;
                if (w_producing) begin
                    r_out_valid <= 1'b1;
                    r_out_avg   <= w_avg;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_accept && !i_clear)
            r_history[r_wr_ptr] <= bus.input_sample;
    end

    assign bus.input_ready    = w_input_ready;
    assign bus.input_overflow = r_overflow;
    assign bus.output_valid   = r_out_valid;
    assign bus.output_average = r_out_avg;
endmodule

// File: tb/tb_averager_moving_powers_of_two.sv
// Bench for averager_moving_powers_of_two: directed scenarios plus random traffic,
// every cycle compared against a queue-based window model.
module tb_averager_moving_powers_of_two;
    localparam int WW = 8;
    localparam int ME = 3;
    localparam int EW = 3;

    logic clk = 1'b0;
    logic clear;

    averager_moving_powers_of_two_if #(.WORD_WIDTH(WW), .EXPONENT_WIDTH(EW)) bus();

    averager_moving_powers_of_two #(
        .WORD_WIDTH(WW), .MAX_EXPONENT(ME), .EXPONENT_WIDTH(EW)
    ) dut (
        .i_clock (clk),
        .i_clear (clear),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int got_q[$];

    bit m_started = 1'b0;
    bit m_valid   = 1'b0;
    int m_avg     = 0;
    int m_e       = 0;
    int m_win[$];
    bit m_prev_restart = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp_e(input int e);
        return (e > ME) ? ME : e;
    endfunction

    function automatic int window_avg(input int s, input int e);
        int den;
        int r;
        den = 1 << e;
`ifdef AVERAGER_MOVING_ROUNDING_EN
        if (s >= 0) r = (s + den / 2) / den;
        else        r = -((-s + den / 2) / den);
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
`else
        r = s / den;
`endif
        return r;
    endfunction

    // Compare against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        int  n;
        int  s;
        bit  m_ready;
        bit  pulse;
        n       = 1 << m_e;
        pulse   = bus.restart_average && !m_prev_restart;
        m_ready = !pulse && !((m_win.size() >= n - 1) && m_valid && !bus.output_ready);
        if (m_started) begin
            check("output_valid", int'(bus.output_valid), int'(m_valid));
            check("output_average", int'($signed(bus.output_average)), m_avg);
            check("input_overflow", int'(bus.input_overflow), 0);
            if (!clear) check("input_ready", int'(bus.input_ready), int'(m_ready));
            if (bus.output_valid && bus.output_ready && !clear)
                got_q.push_back(int'($signed(bus.output_average)));
        end
        if (clear || pulse) begin
            m_started = 1'b1;
            m_valid   = 1'b0;
            m_avg     = 0;
            m_e       = clamp_e(int'(bus.window_exponent));
            m_win.delete();
        end else begin
            if (m_valid && bus.output_ready) m_valid = 1'b0;
            if (bus.input_valid && m_ready) begin
                m_win.push_back(int'($signed(bus.input_sample)));
                if (m_win.size() > n) void'(m_win.pop_front());
                if (m_win.size() == n) begin
                    s = 0;
                    foreach (m_win[i]) s += m_win[i];
                    m_valid = 1'b1;
                    m_avg   = window_avg(s, m_e);
                end
            end
        end
        m_prev_restart = bus.restart_average;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s);
        int n;
        n = 0;
        bus.input_valid  = 1'b1;
        bus.input_sample = WW'(s);
        @(negedge clk);
        while (!bus.input_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.input_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: input_ready=%0d, required 1", bus.input_ready);
        end
        tick();
        bus.input_valid = 1'b0;
    endtask

    task automatic restart_to(input int e);
        bus.window_exponent = EW'(e);
        bus.restart_average = 1'b1;
        tick();
        bus.restart_average = 1'b0;
        tick();
    endtask

    task automatic drain();
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        clear               = 1'b1;
        bus.window_exponent = EW'(2);
        bus.restart_average = 1'b0;
        bus.input_valid     = 1'b0;
        bus.input_sample    = '0;
        bus.output_ready    = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset_valid", int'(bus.output_valid), 0);
        check("reset_average", int'($signed(bus.output_average)), 0);
        check("reset_overflow", int'(bus.input_overflow), 0);
        tick();
        clear = 1'b0;
        @(negedge clk);
        check("ready_after_clear", int'(bus.input_ready), 1);
        tick();

        // Fill and slide, E=2
        got_q.delete();
        send(4); send(8); send(12);
        tick();
        check("fill_no_output", got_q.size(), 0);
        send(16); send(20); send(24);
        drain();
        check("slide_count", got_q.size(), 3);
        check("slide_first", got_q[0], 10);
        check("slide_second", got_q[1], 14);
        check("slide_third", got_q[2], 18);

        // Signed rounding
        restart_to(2);
        got_q.delete();
        send(-1); send(-2); send(-2); send(-2);
        drain();
        check("neg_count", got_q.size(), 1);
`ifdef AVERAGER_MOVING_ROUNDING_EN
        check("neg_round", got_q[0], -2);
`else
        check("neg_round", got_q[0], -1);
`endif
        restart_to(2);
        got_q.delete();
        send(1); send(2); send(2); send(2);
        drain();
`ifdef AVERAGER_MOVING_ROUNDING_EN
        check("pos_round", got_q[0], 2);
`else
        check("pos_round", got_q[0], 1);
`endif

        // Backpressure: window 2,2,2,5 then 2,2,5,9
        got_q.delete();
        bus.output_ready = 1'b0;
        send(5);
        bus.input_valid  = 1'b1;
        bus.input_sample = WW'(9);
        repeat (3) begin
            @(negedge clk);
            check("bp_ready", int'(bus.input_ready), 0);
            check("bp_valid", int'(bus.output_valid), 1);
`ifdef AVERAGER_MOVING_ROUNDING_EN
            check("bp_hold", int'($signed(bus.output_average)), 3);
`else
            check("bp_hold", int'($signed(bus.output_average)), 2);
`endif
            tick();
        end
        bus.output_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", int'(bus.input_ready), 1);
        tick();
        bus.input_valid = 1'b0;
        drain();
        check("bp_count", got_q.size(), 2);
`ifdef AVERAGER_MOVING_ROUNDING_EN
        check("bp_next", got_q[1], 5);
`else
        check("bp_next", got_q[1], 4);
`endif

        // Restart mid-fill
        restart_to(3);
        repeat (5) send(100);
        restart_to(1);
        got_q.delete();
        send(6); send(10);
        drain();
        check("restart_count", got_q.size(), 1);
        check("restart_avg", got_q[0], 8);

        // Extremes, pointer wrap, exponent clamp
        restart_to(7);
        got_q.delete();
        repeat (20) send(-128);
        drain();
        check("min_count", got_q.size(), 13);
        for (int i = 0; i < got_q.size(); i++) check("min_avg", got_q[i], -128);
        repeat (10) send(127);
        drain();
        check("max_count", got_q.size(), 23);
        check("max_avg", got_q[got_q.size()-1], 127);
        check("extreme_overflow", int'(bus.input_overflow), 0);

        // Clear while an output is pending
        bus.output_ready = 1'b0;
        send(50);
        clear = 1'b1;
        bus.window_exponent = EW'(2);
        tick();
        clear = 1'b0;
        @(negedge clk);
        check("clear_drops_valid", int'(bus.output_valid), 0);
        tick();
        bus.output_ready = 1'b1;
        got_q.delete();
        send(1); send(2); send(3);
        drain();
        check("clear_refill", got_q.size(), 0);
        send(6);
        drain();
        check("clear_first_out", got_q.size(), 1);
        check("clear_first_avg", got_q[0], 3);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            bus.input_valid = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 9);
            if (r == 0)      bus.input_sample = WW'(-128);
            else if (r == 1) bus.input_sample = WW'(127);
            else             bus.input_sample = WW'($urandom_range(0, 255));
            bus.output_ready    = ($urandom_range(0, 3) != 0);
            bus.window_exponent = EW'($urandom_range(0, 7));
            bus.restart_average = ($urandom_range(0, 39) == 0);
            clear               = ($urandom_range(0, 299) == 0);
            tick();
        end
        clear               = 1'b0;
        bus.input_valid     = 1'b0;
        bus.restart_average = 1'b0;
        bus.output_ready    = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
